// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 15;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StOwn      = 2'd1,
        StHandover = 2'd2
    } state_e;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } master_e;

    // Round-robin pick: on a tie the master that did not own the bus last wins.
    function automatic master_e pick_winner(input logic req_1, input logic req_2,
                                            input master_e last);
        master_e win;
        if (req_1 && req_2) begin
            if (last == M1) win = M2;
            else            win = M1;
        end else if (req_1) begin
            win = M1;
        end else begin
            win = M2;
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded hold time and a one-cycle
// turnaround between owners. The owner's address is muxed onto HADDR.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = BUS_ADDR_W,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_1,
    input  logic              REQ_2,
    input  logic [ADDR_W-1:0] HADDR_1,
    input  logic [ADDR_W-1:0] HADDR_2,
    output logic              GNT_1,
    output logic              GNT_2,
    output logic [ADDR_W-1:0] HADDR,
    output logic              BUS_BUSY,
    output logic              PREEMPT
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state;
    master_e          last;
    logic [CNT_W-1:0] hold_cnt;

    logic    owner_req;
    logic    other_req;
    logic    hold_done;
    master_e winner;

    // While owning, 'last' is always the current owner.
    assign owner_req = (last == M1) ? REQ_1 : REQ_2;
    assign other_req = (last == M1) ? REQ_2 : REQ_1;
    assign hold_done = (hold_cnt == HOLD_LAST);
    assign winner    = pick_winner(REQ_1, REQ_2, last);
    assign BUS_BUSY  = GNT_1 | GNT_2;

    // Arbitration state, hold counter and registered grants.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= StIdle;
            last     <= M2;
            hold_cnt <= '0;
            GNT_1    <= 1'b0;
            GNT_2    <= 1'b0;
            PREEMPT  <= 1'b0;
        end else begin
            PREEMPT <= 1'b0;
            unique case (state)
                StIdle, StHandover: begin
                    if (REQ_1 || REQ_2) begin
                        state    <= StOwn;
                        last     <= winner;
                        hold_cnt <= '0;
                        GNT_1    <= (winner == M1);
                        GNT_2    <= (winner == M2);
                    end else begin
                        state <= StIdle;
                        GNT_1 <= 1'b0;
                        GNT_2 <= 1'b0;
                    end
                end
                StOwn: begin
                    if (!owner_req) begin
                        state <= StHandover;
                        GNT_1 <= 1'b0;
                        GNT_2 <= 1'b0;
                    end else if (hold_done && other_req) begin
                        state   <= StHandover;
                        GNT_1   <= 1'b0;
                        GNT_2   <= 1'b0;
                        PREEMPT <= 1'b1;
                    end else if (!hold_done) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    GNT_1 <= 1'b0;
                    GNT_2 <= 1'b0;
                end
            endcase
        end
    end

    // Address mux straight from the registered grants; zero selects no slave.
    always_comb begin
        HADDR = '0;
        if (GNT_1)      HADDR = HADDR_1;
        else if (GNT_2) HADDR = HADDR_2;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random request
// traffic compared against a tenure-based reference model.
module tb_bus_arbiter;

    localparam int unsigned AW       = 15;
    localparam int unsigned MAX_HOLD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_1, req_2;
    logic [AW-1:0] haddr_1, haddr_2;
    logic          gnt_1, gnt_2, busy, preempt;
    logic [AW-1:0] haddr;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: owner 0 = nobody, 1 = M1, 2 = M2; held = cycles of tenure.
    int m_owner;
    int m_held;
    int m_last;
    bit m_pre;

    bus_arbiter #(
        .ADDR_W  (AW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ_1   (req_1),
        .REQ_2   (req_2),
        .HADDR_1 (haddr_1),
        .HADDR_2 (haddr_2),
        .GNT_1   (gnt_1),
        .GNT_2   (gnt_2),
        .HADDR   (haddr),
        .BUS_BUSY(busy),
        .PREEMPT (preempt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = 0;
        m_held  = 0;
        m_last  = 2;
        m_pre   = 1'b0;
    endtask

    task automatic model_step(input logic r1, input logic r2);
        logic own_r, oth_r;
        m_pre = 1'b0;
        if (m_owner == 0) begin
            if (r1 || r2) begin
                if (r1 && r2) m_owner = (m_last == 1) ? 2 : 1;
                else          m_owner = r1 ? 1 : 2;
                m_last = m_owner;
                m_held = 1;
            end
        end else begin
            own_r = (m_owner == 1) ? r1 : r2;
            oth_r = (m_owner == 1) ? r2 : r1;
            if (!own_r) begin
                m_owner = 0;
            end else if (m_held >= MAX_HOLD && oth_r) begin
                m_owner = 0;
                m_pre   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Leaves the bench 3 time units after a rising edge with reset released.
    task automatic apply_reset();
        rst     = 1'b0;
        req_1   = 1'b0;
        req_2   = 1'b0;
        haddr_1 = '0;
        haddr_2 = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        haddr_1 = 15'h1111;
        haddr_2 = 15'h2222;
        req_1   = 1'b0;
        req_2   = 1'b0;
        #1;
        tests_run++;
        if ({gnt_1, gnt_2, busy, preempt} !== 4'b0000 || haddr !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: gnt1=%b gnt2=%b busy=%b pre=%b haddr=%h, expected all 0",
                     gnt_1, gnt_2, busy, preempt, haddr);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({gnt_1, gnt_2, busy, preempt} !== 4'b0000 || haddr !== '0) begin
                tests_failed++;
                $display("FAIL idle_no_req: gnt1=%b gnt2=%b busy=%b haddr=%h, expected 0",
                         gnt_1, gnt_2, busy, haddr);
            end
        end
    endtask

    task automatic test_tie_grant();
        apply_reset();
        haddr_1 = 15'h2000;
        haddr_2 = 15'h4000;
        req_1   = 1'b1;
        req_2   = 1'b1;
        #1;
        tests_run++;
        if (gnt_1 !== 1'b0 || gnt_2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_pre_edge: gnt1=%b gnt2=%b, expected 0 0", gnt_1, gnt_2);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (gnt_1 !== 1'b1 || gnt_2 !== 1'b0 || busy !== 1'b1 || haddr !== 15'h2000) begin
            tests_failed++;
            $display("FAIL tie_first_grant: gnt1=%b gnt2=%b busy=%b haddr=%h, expected 1 0 1 2000",
                     gnt_1, gnt_2, busy, haddr);
        end
    endtask

    // Continues from test_tie_grant with M1 owning.
    task automatic test_release_handover();
        req_1 = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (gnt_1 !== 1'b0 || gnt_2 !== 1'b0 || haddr !== '0 || preempt !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_gap: gnt1=%b gnt2=%b haddr=%h pre=%b, expected 0 0 0 0",
                     gnt_1, gnt_2, haddr, preempt);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (gnt_2 !== 1'b1 || gnt_1 !== 1'b0 || haddr !== 15'h4000) begin
            tests_failed++;
            $display("FAIL release_m2_grant: gnt1=%b gnt2=%b haddr=%h, expected 0 1 4000",
                     gnt_1, gnt_2, haddr);
        end
        haddr_2 = 15'h4004;
        #1;
        tests_run++;
        if (haddr !== 15'h4004) begin
            tests_failed++;
            $display("FAIL haddr_comb_mux: haddr=%h, expected 4004", haddr);
        end
    endtask

    // Both masters requesting forever: 16 cycles M1, gap+preempt, 16 cycles M2, gap+preempt.
    task automatic test_preempt_alternation();
        int       pulses;
        int       p;
        bit [2:0] exp;
        apply_reset();
        haddr_1 = 15'h2000;
        haddr_2 = 15'h4000;
        req_1   = 1'b1;
        req_2   = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            p = i % (2 * MAX_HOLD + 2);
            if (p < MAX_HOLD)                           exp = 3'b100;
            else if (p == MAX_HOLD || p == 2 * MAX_HOLD + 1) exp = 3'b001;
            else                                        exp = 3'b010;
            if (preempt === 1'b1) pulses++;
            tests_run++;
            if ({gnt_1, gnt_2, preempt} !== exp) begin
                tests_failed++;
                $display("FAIL preempt_pattern cycle %0d: {gnt1,gnt2,pre}=%b, expected %b",
                         i, {gnt_1, gnt_2, preempt}, exp);
            end
        end
        tests_run++;
        if (pulses != 4) begin
            tests_failed++;
            $display("FAIL preempt_pulse_count: got %0d, expected 4", pulses);
        end
    endtask

    task automatic test_hold_saturation();
        int g1_cycles;
        int pulses;
        apply_reset();
        haddr_1   = 15'h1234;
        req_1     = 1'b1;
        g1_cycles = 0;
        pulses    = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (gnt_1 === 1'b1 && haddr === 15'h1234) g1_cycles++;
            if (preempt !== 1'b0) pulses++;
        end
        tests_run++;
        if (g1_cycles != 40 || pulses != 0) begin
            tests_failed++;
            $display("FAIL solo_hold: gnt1 cycles=%0d preempts=%0d, expected 40 0",
                     g1_cycles, pulses);
        end
        // Counter is saturated, so a late competitor forces the owner off at once.
        req_2 = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (gnt_1 !== 1'b0 || preempt !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturated_preempt: gnt1=%b pre=%b, expected 0 1", gnt_1, preempt);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (gnt_2 !== 1'b1 || gnt_1 !== 1'b0 || preempt !== 1'b0) begin
            tests_failed++;
            $display("FAIL preempted_loses_tie: gnt1=%b gnt2=%b pre=%b, expected 0 1 0",
                     gnt_1, gnt_2, preempt);
        end
    endtask

    task automatic test_reset_mid_transfer();
        apply_reset();
        haddr_1 = 15'h2000;
        req_1   = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (gnt_1 !== 1'b1 || haddr !== 15'h2000) begin
            tests_failed++;
            $display("FAIL midreset_setup: gnt1=%b haddr=%h, expected 1 2000", gnt_1, haddr);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (gnt_1 !== 1'b0 || busy !== 1'b0 || haddr !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: gnt1=%b busy=%b haddr=%h, expected 0 0 0",
                     gnt_1, busy, haddr);
        end
        #2;
        rst   = 1'b1;
        req_1 = 1'b0;
    endtask

    task automatic test_random_traffic();
        logic [AW-1:0] exp_addr;
        bit   [3:0]    exp_ctl;
        apply_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(15) == 0) req_1 = ~req_1;
            if ($urandom_range(15) == 0) req_2 = ~req_2;
            haddr_1 = AW'($urandom);
            haddr_2 = AW'($urandom);
            @(posedge clk);
            model_step(req_1, req_2);
            #1;
            exp_addr = (m_owner == 1) ? haddr_1 : (m_owner == 2) ? haddr_2 : '0;
            exp_ctl  = {m_owner == 1, m_owner == 2, m_owner != 0, m_pre};
            tests_run++;
            if ({gnt_1, gnt_2, busy, preempt} !== exp_ctl || haddr !== exp_addr) begin
                tests_failed++;
                $display("FAIL random_model cycle %0d: {g1,g2,busy,pre}=%b haddr=%h, expected %b %h",
                         i, {gnt_1, gnt_2, busy, preempt}, haddr, exp_ctl, exp_addr);
            end
            tests_run++;
            if ((gnt_1 & gnt_2) !== 1'b0 || busy !== (gnt_1 | gnt_2) ||
                (busy === 1'b0 && haddr !== '0)) begin
                tests_failed++;
                $display("FAIL random_invariant cycle %0d: g1=%b g2=%b busy=%b haddr=%h",
                         i, gnt_1, gnt_2, busy, haddr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie_grant();
        test_release_handover();
        test_preempt_alternation();
        test_hold_saturation();
        test_reset_mid_transfer();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
